dm_stage: RTL and testbench



---
 rtl/dm_stage_if.sv | 22 ++
 rtl/dm_stage.sv | 107 ++++++++++
 tb/tb_dm_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dm_stage_if.sv
// Memory-stage bus between the E/M register side and the data memory.
// The master drives the access; the slave returns load data and the address-error report.
interface dm_stage_if;
   logic [31:0] PcM;
   logic        MemWriteM;
   logic [2:0]  MemOpM;
   logic [31:0] ALUOutM;
   logic [31:0] WriteDataM;
   logic [31:0] ReadDataM;
   logic        ExcM;
   logic [31:0] ExcPcM;

   modport master (
      output PcM, MemWriteM, MemOpM, ALUOutM, WriteDataM,
      input  ReadDataM, ExcM, ExcPcM
   );

   modport slave (
      input  PcM, MemWriteM, MemOpM, ALUOutM, WriteDataM,
      output ReadDataM, ExcM, ExcPcM
   );
endinterface

// File: rtl/dm_stage.sv
// MIPS memory-stage data memory: byte-lane stores, sign/zero-extended combinational loads.
// Define DM_ADDR_EXC_EN to enable alignment/range checking with ExcM/ExcPcM reporting.
module dm_stage #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic      clk,
   input  logic      reset,
   dm_stage_if.slave bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [31:0]           mem [DEPTH];
   logic [31:0]           offset;
   logic [DEPTH_LOG2-1:0] wordIdx;
   logic [1:0]            lane;
   logic                  halfSel;
   logic                  isHalf;
   logic                  isByte;
   logic                  isSigned;
   logic [3:0]            byteEn;
   logic [31:0]           laneData;
   logic [31:0]           word;
   logic [15:0]           half;
   logic [7:0]            oneByte;
   logic [31:0]           loadData;
   logic                  storeEn;

   assign offset   = bus.ALUOutM - BASE_ADDR;
   assign wordIdx  = offset[DEPTH_LOG2+1:2];
   assign lane     = bus.ALUOutM[1:0];
   assign halfSel  = bus.ALUOutM[1];
   assign isHalf   = (bus.MemOpM == 3'b001) || (bus.MemOpM == 3'b010);
   assign isByte   = (bus.MemOpM == 3'b011) || (bus.MemOpM == 3'b100);
   assign isSigned = (bus.MemOpM == 3'b001) || (bus.MemOpM == 3'b011);

   // Upper offset bits wrap away; the lane comes straight from the address.
   logic unusedOffset;
   assign unusedOffset = &{1'b0, offset[31:DEPTH_LOG2+2], offset[1:0]};

   always_comb begin
      byteEn   = 4'b1111;
      laneData = bus.WriteDataM;
      if (isHalf) begin
         byteEn   = halfSel ? 4'b1100 : 4'b0011;
         laneData = {2{bus.WriteDataM[15:0]}};
      end else if (isByte) begin
         byteEn   = 4'b0001 << lane;
         laneData = {4{bus.WriteDataM[7:0]}};
      end
   end

   assign word    = mem[wordIdx];
   assign half    = halfSel ? word[31:16] : word[15:0];
   assign oneByte = word[8*lane +: 8];

   always_comb begin
      loadData = word;
      if (isHalf)
         loadData = {{16{isSigned & half[15]}}, half};
      else if (isByte)
         loadData = {{24{isSigned & oneByte[7]}}, oneByte};
   end

`ifdef DM_ADDR_EXC_EN
   logic        misaligned;
   logic        outOfRange;
   logic        excHit;
   logic [31:0] excPcReg;

   assign misaligned = (!isHalf && !isByte && (lane != 2'b00)) || (isHalf && lane[0]);
   assign outOfRange = ({1'b0, bus.ALUOutM} < {1'b0, BASE_ADDR}) ||
                       ({1'b0, bus.ALUOutM} >= ({1'b0, BASE_ADDR} + 33'(4 * DEPTH)));
   assign excHit     = misaligned | outOfRange;

   assign bus.ExcM      = excHit;
   assign bus.ExcPcM    = excPcReg;
   assign bus.ReadDataM = excHit ? 32'h0 : loadData;
   assign storeEn       = bus.MemWriteM & ~excHit;

   always_ff @(posedge clk) begin
      if (reset)
         excPcReg <= 32'h0;
      else if (excHit)
         excPcReg <= bus.PcM;
   end
`else
   logic unusedPc;
   assign unusedPc      = &{1'b0, bus.PcM};
   assign bus.ExcM      = 1'b0;
   assign bus.ExcPcM    = 32'h0;
   assign bus.ReadDataM = loadData;
   assign storeEn       = bus.MemWriteM;
`endif

   // Reset wins over a same-cycle store; the whole array clears in one edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= 32'h0;
      end else if (storeEn) begin
         for (int k = 0; k < 4; k++)
            if (byteEn[k])
               mem[wordIdx][8*k +: 8] <= laneData[8*k +: 8];
      end
   end
endmodule

// File: tb/tb_dm_stage.sv
// Scoreboard bench for dm_stage: stimulus queues expected load/exception results, a monitor compares.
// Exception cases run when DM_ADDR_EXC_EN is defined; wrap and half-lane cases otherwise.
module tb_dm_stage;
   logic clk;
   logic reset;

   dm_stage_if bus ();

   dm_stage #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          chkData;
      logic [31:0] expData;
      logic        expExc;
      logic [31:0] expPc;
   } exp_t;

   exp_t expQ[$];
   bit   chkNow;
   int   checks;
   int   errors;

   localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011, LBU = 3'b100;

   always @(negedge clk) begin
      if (chkNow) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL monitor: output presented with no expected entry queued");
         end else begin
            exp_t e;
            e = expQ.pop_front();
            if (e.chkData) begin
               checks++;
               if (bus.ReadDataM !== e.expData) begin
                  errors++;
                  $display("FAIL %s ReadDataM got %h want %h", e.name, bus.ReadDataM, e.expData);
               end
            end
            checks++;
            if (bus.ExcM !== e.expExc) begin
               errors++;
               $display("FAIL %s ExcM got %b want %b", e.name, bus.ExcM, e.expExc);
            end
            checks++;
            if (bus.ExcPcM !== e.expPc) begin
               errors++;
               $display("FAIL %s ExcPcM got %h want %h", e.name, bus.ExcPcM, e.expPc);
            end
         end
      end
   end

   task automatic doCycle(input bit rst, input bit we, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc,
                          input bit chk, input bit chkData, input string nm,
                          input logic [31:0] expD, input logic expE, input logic [31:0] expPc);
      exp_t e;
      @(posedge clk);
      #1;
      reset          = rst;
      bus.MemWriteM  = we;
      bus.MemOpM     = op;
      bus.ALUOutM    = addr;
      bus.WriteDataM = wd;
      bus.PcM        = pc;
      chkNow         = chk;
      if (chk) begin
         e.name    = nm;
         e.chkData = chkData;
         e.expData = expD;
         e.expExc  = expE;
         e.expPc   = expPc;
         expQ.push_back(e);
      end
   endtask

   task automatic store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
      doCycle(1'b0, 1'b1, op, addr, wd, 32'h0, 1'b0, 1'b0, "", 32'h0, 1'b0, 32'h0);
   endtask

   task automatic load(input string nm, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] expD, input logic [31:0] expPc);
      doCycle(1'b0, 1'b0, op, addr, 32'h0, 32'h0, 1'b1, 1'b1, nm, expD, 1'b0, expPc);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      chkNow = 1'b0;
      reset  = 1'b1;
      bus.MemWriteM = 1'b0; bus.MemOpM = LW; bus.ALUOutM = 32'h0;
      bus.WriteDataM = 32'h0; bus.PcM = 32'h0;

      doCycle(1'b1, 1'b0, LW, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, "", 32'h0, 1'b0, 32'h0);
      doCycle(1'b1, 1'b0, LW, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, "", 32'h0, 1'b0, 32'h0);

      load("rst_lw_0",   LW, 32'h0,   32'h0, 32'h0);
      load("rst_lw_ffc", LW, 32'hFFC, 32'h0, 32'h0);

      // Same-cycle load during the store sees the pre-store word.
      doCycle(1'b0, 1'b1, LW, 32'h10, 32'h8899AABB, 32'h0, 1'b1, 1'b1, "sw_same_cycle",
              32'h0, 1'b0, 32'h0);
      load("lb_13",  LB,  32'h13, 32'hFFFFFF88, 32'h0);
      load("lbu_13", LBU, 32'h13, 32'h00000088, 32'h0);
      load("lh_10",  LH,  32'h10, 32'hFFFFAABB, 32'h0);
      load("lhu_12", LHU, 32'h12, 32'h00008899, 32'h0);
      load("lbu_10", LBU, 32'h10, 32'h000000BB, 32'h0);

      store(LB, 32'h11, 32'h11223344);
      load("lw_after_sb", LW, 32'h10, 32'h889944BB, 32'h0);
      store(LHU, 32'h12, 32'h0000CAFE);
      load("lw_after_sh", LW, 32'h10, 32'hCAFE44BB, 32'h0);
      load("lh_12_neg",   LH, 32'h12, 32'hFFFFCAFE, 32'h0);
      load("lb_11_pos",   LB, 32'h11, 32'h00000044, 32'h0);

      // Reset in the same cycle as a store discards the store and clears everything.
      doCycle(1'b1, 1'b1, LW, 32'h20, 32'h12345678, 32'h0, 1'b0, 1'b0, "", 32'h0, 1'b0, 32'h0);
      load("lw_20_after_rst", LW, 32'h20, 32'h0, 32'h0);
      load("lw_10_after_rst", LW, 32'h10, 32'h0, 32'h0);

      doCycle(1'b0, 1'b1, LW, 32'h20, 32'h12345678, 32'h0, 1'b1, 1'b1, "sw20_same_cycle",
              32'h0, 1'b0, 32'h0);
      load("lw_20_next",  LW,     32'h20, 32'h12345678, 32'h0);
      load("op111_word",  3'b111, 32'h20, 32'h12345678, 32'h0);
      load("op101_word",  3'b101, 32'h20, 32'h12345678, 32'h0);

`ifdef DM_ADDR_EXC_EN
      doCycle(1'b0, 1'b1, LW, 32'h22, 32'hFFFFFFFF, 32'h3010, 1'b1, 1'b0, "sw_misaligned",
              32'h0, 1'b1, 32'h0);
      load("lw_20_unchanged", LW, 32'h20, 32'h12345678, 32'h3010);
      doCycle(1'b0, 1'b0, LW, 32'h1000, 32'h0, 32'h3020, 1'b1, 1'b1, "lw_out_of_range",
              32'h0, 1'b1, 32'h3010);
      load("excpc_updated", LW, 32'h20, 32'h12345678, 32'h3020);
      doCycle(1'b0, 1'b0, LH, 32'h21, 32'h0, 32'h3030, 1'b1, 1'b1, "lh_misaligned",
              32'h0, 1'b1, 32'h3020);
      load("lbu_21_aligned_ok", LBU, 32'h21, 32'h00000056, 32'h3030);
      doCycle(1'b1, 1'b0, LW, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, "", 32'h0, 1'b0, 32'h0);
      load("excpc_reset", LW, 32'h20, 32'h0, 32'h0);
`else
      store(LW, 32'h1000, 32'hDEADBEEF);
      load("wrap_lw_0", LW, 32'h0, 32'hDEADBEEF, 32'h0);
      store(LHU, 32'h21, 32'h0000BEEF);
      load("sh_ignores_a0", LW, 32'h20, 32'h1234BEEF, 32'h0);
      store(LB, 32'h2003, 32'h000000A5);
      load("wrap_sb_lane3", LW, 32'h0, 32'hA5ADBEEF, 32'h0);
`endif

      @(posedge clk);
      #1;
      chkNow = 1'b0;
      for (int i = 0; i < 10 && expQ.size() != 0; i++)
         @(posedge clk);
      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected entries left, want 0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
